// File: rtl/muldiv_arbiter_if.sv
// muldiv_arbiter_if: issue-slot, mul/div-unit and writeback signals of the muldiv arbiter
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`endif
interface muldiv_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH = `ALU_OP_WIDTH
);
    logic req_0;
    logic req_1;
    logic [OP_WIDTH-1:0] op_0;
    logic [OP_WIDTH-1:0] op_1;
    logic [DATA_WIDTH-1:0] s1_0;
    logic [DATA_WIDTH-1:0] s2_0;
    logic [DATA_WIDTH-1:0] s1_1;
    logic [DATA_WIDTH-1:0] s2_1;
    logic ack_0;
    logic ack_1;
    logic flush;
    logic md_start;
    logic [OP_WIDTH-1:0] md_op;
    logic [DATA_WIDTH-1:0] md_s1;
    logic [DATA_WIDTH-1:0] md_s2;
    logic md_done;
    logic [DATA_WIDTH-1:0] md_result;
    logic res_valid;
    logic res_slot;
    logic [DATA_WIDTH-1:0] res_data;
    logic res_ready;
    logic stall;

    modport slave (
        input req_0, req_1, op_0, op_1, s1_0, s2_0, s1_1, s2_1, flush, md_done, md_result, res_ready,
        output ack_0, ack_1, md_start, md_op, md_s1, md_s2, res_valid, res_slot, res_data, stall
    );

    modport master (
        output req_0, req_1, op_0, op_1, s1_0, s2_0, s1_1, s2_1, flush, md_done, md_result, res_ready,
        input ack_0, ack_1, md_start, md_op, md_s1, md_s2, res_valid, res_slot, res_data, stall
    );
endinterface

// File: rtl/muldiv_arbiter.sv
// muldiv_arbiter: shares one multi-cycle mul/div unit between two issue slots; MULDIV_DUAL_ACCEPT_EN adds a slot-1 pending entry
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`endif
module muldiv_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH = `ALU_OP_WIDTH
) (
    input logic clk,
    input logic rst,
    muldiv_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, HOLD, DRAIN} state_t;

    state_t state;
    logic cur_slot;
    logic pend_valid;

`ifdef MULDIV_DUAL_ACCEPT_EN
    logic [OP_WIDTH-1:0] pend_op;
    logic [DATA_WIDTH-1:0] pend_s1;
    logic [DATA_WIDTH-1:0] pend_s2;
`else
    assign pend_valid = 1'b0;
`endif

    // Hold the pipeline while an op is in flight, a result waits, or slot 1 is queued
    assign bus.stall = (state != IDLE) || pend_valid;

    // Arbitration FSM: launches ops, captures results, drops flushed slot-1 work
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cur_slot <= 1'b0;
`ifdef MULDIV_DUAL_ACCEPT_EN
            pend_valid <= 1'b0;
`endif
            bus.ack_0 <= 1'b0;
            bus.ack_1 <= 1'b0;
            bus.md_start <= 1'b0;
            bus.md_op <= OP_WIDTH'(0);
            bus.md_s1 <= DATA_WIDTH'(0);
            bus.md_s2 <= DATA_WIDTH'(0);
            bus.res_valid <= 1'b0;
            bus.res_slot <= 1'b0;
            bus.res_data <= DATA_WIDTH'(0);
        end else begin
            bus.ack_0 <= 1'b0;
            bus.ack_1 <= 1'b0;
            bus.md_start <= 1'b0;
`ifdef MULDIV_DUAL_ACCEPT_EN
            if (bus.flush)
                pend_valid <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (bus.req_0) begin
                        bus.ack_0 <= 1'b1;
                        bus.md_start <= 1'b1;
                        bus.md_op <= bus.op_0;
                        bus.md_s1 <= bus.s1_0;
                        bus.md_s2 <= bus.s2_0;
                        cur_slot <= 1'b0;
                        state <= BUSY;
`ifdef MULDIV_DUAL_ACCEPT_EN
                        if (bus.req_1 && !bus.flush) begin
                            bus.ack_1 <= 1'b1;
                            pend_valid <= 1'b1;
                            pend_op <= bus.op_1;
                            pend_s1 <= bus.s1_1;
                            pend_s2 <= bus.s2_1;
                        end
`endif
                    end else if (bus.req_1 && !bus.flush) begin
                        bus.ack_1 <= 1'b1;
                        bus.md_start <= 1'b1;
                        bus.md_op <= bus.op_1;
                        bus.md_s1 <= bus.s1_1;
                        bus.md_s2 <= bus.s2_1;
                        cur_slot <= 1'b1;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.flush && cur_slot) begin
                        state <= bus.md_done ? IDLE : DRAIN;
                    end else if (bus.md_done) begin
                        bus.res_valid <= 1'b1;
                        bus.res_slot <= cur_slot;
                        bus.res_data <= bus.md_result;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.flush && bus.res_slot) begin
                        bus.res_valid <= 1'b0;
                        state <= IDLE;
                    end else if (bus.res_ready) begin
                        bus.res_valid <= 1'b0;
                        state <= IDLE;
`ifdef MULDIV_DUAL_ACCEPT_EN
                        if (pend_valid && !bus.flush) begin
                            pend_valid <= 1'b0;
                            bus.md_start <= 1'b1;
                            bus.md_op <= pend_op;
                            bus.md_s1 <= pend_s1;
                            bus.md_s2 <= pend_s2;
                            cur_slot <= 1'b1;
                            state <= BUSY;
                        end
`endif
                    end
                end
                DRAIN: begin
                    if (bus.md_done)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_arbiter.sv
// tb_muldiv_arbiter: directed scoreboard bench for muldiv_arbiter with a 3-cycle mul/div unit model
module tb_muldiv_arbiter;
    localparam int DW = 32;
    localparam int OW = 4;
    localparam logic [OW-1:0] MUL = 4'd1;
    localparam logic [OW-1:0] DIV = 4'd2;
`ifdef MULDIV_DUAL_ACCEPT_EN
    localparam int DUAL = 1;
`else
    localparam int DUAL = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    muldiv_arbiter_if #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) bus ();
    muldiv_arbiter #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int vectors = 0;
    int errors = 0;
    int starts = 0;
    int delivered = 0;
    int s0;
    int d0;
    bit outstanding = 1'b0;
    logic [DW:0] sb[$];
    logic [DW:0] exp_v;

    int u_cnt = 0;
    logic u_done = 1'b0;
    logic [DW-1:0] u_res = '0;
    logic stray = 1'b0;

    assign bus.md_done = u_done | stray;
    assign bus.md_result = stray ? 32'hBADBAD00 : u_res;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ack0"}, bus.ack_0, 0);
        check({tag, "_ack1"}, bus.ack_1, 0);
        check({tag, "_md_start"}, bus.md_start, 0);
        check({tag, "_md_op"}, bus.md_op, 0);
        check({tag, "_md_s1"}, bus.md_s1, 0);
        check({tag, "_md_s2"}, bus.md_s2, 0);
        check({tag, "_res_valid"}, bus.res_valid, 0);
        check({tag, "_res_slot"}, bus.res_slot, 0);
        check({tag, "_res_data"}, bus.res_data, 0);
        check({tag, "_stall"}, bus.stall, 0);
    endtask

    task automatic wait_res(input string tag);
        for (int i = 0; i < 60 && !bus.res_valid; i++) tick();
        check(tag, bus.res_valid, 1);
    endtask

    task automatic wait_empty(input string tag);
        for (int i = 0; i < 100 && (sb.size() != 0 || bus.stall); i++) tick();
        check(tag, {bus.stall, 32'(sb.size())}, 0);
    endtask

    // Shared mul/div unit model: result three cycles after it sees md_start
    always @(posedge clk) begin
        if (rst) begin
            u_cnt <= 0;
            u_done <= 1'b0;
        end else begin
            u_done <= 1'b0;
            if (bus.md_start) begin
                u_cnt <= 3;
                u_res <= (bus.md_op == MUL) ? bus.md_s1 * bus.md_s2 : bus.md_s1 / bus.md_s2;
            end else if (u_cnt == 1) begin
                u_cnt <= 0;
                u_done <= 1'b1;
            end else if (u_cnt > 1) begin
                u_cnt <= u_cnt - 1;
            end
        end
    end

    // Monitor: launch overlap and result scoreboard
    always @(negedge clk) begin
        if (rst) begin
            outstanding = 1'b0;
        end else begin
            if (bus.md_start) begin
                starts++;
                check("single_launch", outstanding, 0);
                outstanding = 1'b1;
            end
            if (bus.md_done)
                outstanding = 1'b0;
            if (bus.res_valid && bus.res_ready && !(bus.flush && bus.res_slot)) begin
                if (sb.size() == 0) begin
                    check("unexpected_res", bus.res_valid, 0);
                end else begin
                    exp_v = sb.pop_front();
                    check("res_slot", bus.res_slot, exp_v[DW]);
                    check("res_data", bus.res_data, exp_v[DW-1:0]);
                    delivered++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_0 = 1'b0;
        bus.req_1 = 1'b0;
        bus.op_0 = '0;
        bus.op_1 = '0;
        bus.s1_0 = '0;
        bus.s2_0 = '0;
        bus.s1_1 = '0;
        bus.s2_1 = '0;
        bus.flush = 1'b0;
        bus.res_ready = 1'b0;
        rst = 1'b1;
        tick(3);
        check_zero("reset");
        rst = 1'b0;
        tick();

        // single op 7*6 with exact latency
        bus.res_ready = 1'b1;
        bus.req_0 = 1'b1;
        bus.op_0 = MUL;
        bus.s1_0 = 7;
        bus.s2_0 = 6;
        sb.push_back({1'b0, 32'd42});
        tick();
        check("single_ack0", bus.ack_0, 1);
        check("single_start", bus.md_start, 1);
        check("single_md_op", bus.md_op, MUL);
        check("single_md_s1", bus.md_s1, 7);
        check("single_md_s2", bus.md_s2, 6);
        check("single_stall", bus.stall, 1);
        bus.req_0 = 1'b0;
        tick();
        check("single_ack0_pulse", bus.ack_0, 0);
        check("single_start_pulse", bus.md_start, 0);
        tick(3);
        check("single_done", bus.md_done, 1);
        check("single_no_early_res", bus.res_valid, 0);
        tick();
        check("single_res_valid", bus.res_valid, 1);
        tick();
        check("single_res_clear", bus.res_valid, 0);
        check("single_idle", bus.stall, 0);

        // simultaneous requests: 3*4 on slot 0, 20/5 on slot 1
        s0 = starts;
        d0 = delivered;
        bus.req_0 = 1'b1;
        bus.op_0 = MUL;
        bus.s1_0 = 3;
        bus.s2_0 = 4;
        bus.req_1 = 1'b1;
        bus.op_1 = DIV;
        bus.s1_1 = 20;
        bus.s2_1 = 5;
        sb.push_back({1'b0, 32'd12});
        sb.push_back({1'b1, 32'd4});
        tick();
        check("dual_ack0", bus.ack_0, 1);
        check("dual_ack1_same", bus.ack_1, DUAL);
        bus.req_0 = 1'b0;
        for (int i = 0; i < 60 && !bus.ack_1; i++) tick();
        check("dual_ack1_seen", bus.ack_1, 1);
        check("dual_ack1_order", delivered - d0, DUAL ? 0 : 1);
        bus.req_1 = 1'b0;
        wait_empty("dual_results");
        check("dual_starts", starts - s0, 2);

        // flush blocks slot-1 acceptance in IDLE
        bus.flush = 1'b1;
        bus.req_1 = 1'b1;
        tick();
        check("flush_idle_no_ack1", bus.ack_1, 0);
        check("flush_idle_stall", bus.stall, 0);
        bus.flush = 1'b0;
        sb.push_back({1'b1, 32'd4});
        tick();
        check("unflush_ack1", bus.ack_1, 1);
        bus.req_1 = 1'b0;
        wait_empty("unflush_result");

        // flush of a slot-1 op in BUSY drains silently
        d0 = delivered;
        bus.req_1 = 1'b1;
        tick();
        check("flush1_ack1", bus.ack_1, 1);
        bus.req_1 = 1'b0;
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush1_drain_stall", bus.stall, 1);
        tick(8);
        check("flush1_no_res", bus.res_valid, 0);
        check("flush1_idle", bus.stall, 0);
        check("flush1_none_delivered", delivered - d0, 0);

        // flush during a slot-0 op does not touch it
        bus.req_0 = 1'b1;
        bus.op_0 = MUL;
        bus.s1_0 = 3;
        bus.s2_0 = 4;
        sb.push_back({1'b0, 32'd12});
        tick();
        check("flush0_ack0", bus.ack_0, 1);
        bus.req_0 = 1'b0;
        bus.flush = 1'b1;
        tick(3);
        bus.flush = 1'b0;
        wait_empty("flush0_result");

        // backpressure: result held stable for 5 cycles
        bus.res_ready = 1'b0;
        bus.req_0 = 1'b1;
        bus.op_0 = MUL;
        bus.s1_0 = 7;
        bus.s2_0 = 6;
        sb.push_back({1'b0, 32'd42});
        tick();
        bus.req_0 = 1'b0;
        wait_res("bp_res_valid");
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", bus.res_valid, 1);
            check("bp_hold_data", bus.res_data, 42);
            check("bp_hold_slot", bus.res_slot, 0);
            tick();
        end
        bus.res_ready = 1'b1;
        wait_empty("bp_release");

        // flush of a held slot-1 result withdraws it
        bus.res_ready = 1'b0;
        bus.req_1 = 1'b1;
        bus.op_1 = DIV;
        bus.s1_1 = 20;
        bus.s2_1 = 5;
        tick();
        check("hold1_ack1", bus.ack_1, 1);
        bus.req_1 = 1'b0;
        wait_res("hold1_res_valid");
        check("hold1_slot", bus.res_slot, 1);
        check("hold1_data", bus.res_data, 4);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("hold1_flushed", bus.res_valid, 0);
        check("hold1_idle", bus.stall, 0);
        bus.res_ready = 1'b1;

        // reset mid-operation, then a stray md_done
        bus.req_0 = 1'b1;
        bus.op_0 = MUL;
        bus.s1_0 = 5;
        bus.s2_0 = 5;
        tick();
        bus.req_0 = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check_zero("mid_reset");
        rst = 1'b0;
        tick(3);
        stray = 1'b1;
        tick();
        stray = 1'b0;
        tick(2);
        check("stray_no_res", bus.res_valid, 0);
        check("stray_idle", bus.stall, 0);

        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
